vend_ctrl_multi: RTL and testbench

Parametrised multi-item vending controller and successor to the single-product 5/10 rs FSM. Features:
- Accumulates credit from 5/10/20 rs coins.
- Serves one of NUM_ITEMS products at per-item prices and tracks per-item stock.
- Returns change or refunds one coin per handshake.
Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

---
 rtl/vend_ctrl_multi_pkg.sv | 32 +++
 rtl/vend_change_disp.sv | 60 ++++++
 rtl/vend_ctrl_multi.sv | 149 ++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vend_ctrl_multi_pkg.sv
// vend_pkg: shared encodings for the multi-item vending controller.
//   Coin acceptor encodings, change-hopper encodings, controller state enum
//   and the coin value lookup.
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_20   = 2'b11;

   localparam logic [1:0] CHG_NONE  = 2'b00;
   localparam logic [1:0] CHG_5     = 2'b01;
   localparam logic [1:0] CHG_10    = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_e;

   // Face value in rs; invalid encoding is worth nothing.
   function automatic logic [4:0] coin_value(input logic [1:0] t);
      case (t)
         COIN_5:  return 5'd5;
         COIN_10: return 5'd10;
         COIN_20: return 5'd20;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_change_disp.sv
// vend_change_disp: greedy change dispenser with valid/ready hopper handshake.
//   i_load/i_amount : latch an amount to pay out (multiple of 5)
//   chg_valid/coin  : registered coin offer, held stable until chg_ready
//   o_accept        : coin taken this cycle (chg_valid & chg_ready)
//   o_acc_val       : value of the coin being offered/taken
//   o_done          : the accepted coin is the last one
module vend_change_disp
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [CREDIT_W-1:0] i_amount,
   input  logic                chg_ready,
   output logic                chg_valid,
   output logic [1:0]          chg_coin,
   output logic                o_accept,
   output logic [CREDIT_W-1:0] o_acc_val,
   output logic                o_done
);

   logic [CREDIT_W-1:0] r_rem;
   logic                r_valid;
   logic [1:0]          r_coin;
   logic [CREDIT_W-1:0] w_rem_nxt;

   function automatic logic [1:0] greedy(input logic [CREDIT_W-1:0] amt);
      if (amt >= CREDIT_W'(10))  return CHG_10;
      else if (amt != '0)        return CHG_5;
      else                       return CHG_NONE;
   endfunction

   assign o_accept  = r_valid & chg_ready;
   assign o_acc_val = (r_coin == CHG_10) ? CREDIT_W'(10) : CREDIT_W'(5);
   assign w_rem_nxt = r_rem - o_acc_val;
   assign o_done    = o_accept && (w_rem_nxt == '0);
   assign chg_valid = r_valid;
   assign chg_coin  = r_coin;

   // Offer is recomputed only on load or accept, so it stays frozen while
   // the hopper stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem   <= '0;
         r_valid <= 1'b0;
         r_coin  <= CHG_NONE;
      end else if (i_load) begin
         r_rem   <= i_amount;
         r_valid <= (i_amount != '0);
         r_coin  <= greedy(i_amount);
      end else if (o_accept) begin
         r_rem   <= w_rem_nxt;
         r_valid <= (w_rem_nxt != '0);
         r_coin  <= greedy(w_rem_nxt);
      end
   end

endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller.
//   coin_valid/coin_type : coin acceptor input; coin_reject returns a coin
//   sel_valid/sel_item   : product selection; vend_valid/vend_item dispense
//   err_funds/soldout    : selection refused pulses
//   cancel               : full refund through the change dispenser
//   restock              : reload all stock counters
//   chg_valid/coin/ready : change hopper handshake
//   credit, busy         : registered status
// PRICES default gives item0=25, item1=20, item2=15, item3=10.
module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int CREDIT_W   = 8,
   parameter int CREDIT_MAX = 100,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd10, 8'd15, 8'd20, 8'd25},
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 3,
   localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [1:0]          coin_type,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel_item,
   input  logic                cancel,
   input  logic                restock,
   output logic                coin_reject,
   output logic                vend_valid,
   output logic [SEL_W-1:0]    vend_item,
   output logic                err_funds,
   output logic                err_soldout,
   output logic                chg_valid,
   output logic [1:0]          chg_coin,
   input  logic                chg_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   state_e                            r_state;
   logic [CREDIT_W-1:0]               r_credit;
   logic [NUM_ITEMS-1:0][STOCK_W-1:0] r_stock;
   logic                              r_coin_reject, r_vend_valid, r_err_funds;
   logic                              r_err_soldout, r_busy;
   logic [SEL_W-1:0]                  r_vend_item;

   logic                w_ready_st, w_sel_ok, w_in_stock, w_afford, w_vend;
   logic                w_coin_ok, w_load, w_accept, w_done;
   logic [CREDIT_W-1:0] w_price, w_cred_sel, w_cred_new, w_coin_val, w_acc_val;
   logic [CREDIT_W:0]   w_coin_sum;

   always_comb begin
      w_ready_st = (r_state == IDLE) || (r_state == CREDIT);
      w_sel_ok   = int'(sel_item) < NUM_ITEMS;
      w_price    = w_sel_ok ? PRICES[sel_item*CREDIT_W +: CREDIT_W] : '0;
      w_in_stock = w_sel_ok && (r_stock[sel_item] != '0);
      w_afford   = r_credit >= w_price;
      w_vend     = w_ready_st && !cancel && sel_valid && w_in_stock && w_afford;
      // The coin limit is judged against credit after any purchase this cycle.
      w_cred_sel = w_vend ? (r_credit - w_price) : r_credit;
      w_coin_val = CREDIT_W'(coin_value(coin_type));
      w_coin_sum = {1'b0, w_cred_sel} + {1'b0, w_coin_val};
      w_coin_ok  = coin_valid && (coin_type != COIN_NONE) &&
                   (w_coin_sum <= (CREDIT_W+1)'(CREDIT_MAX));
      w_cred_new = w_coin_ok ? w_coin_sum[CREDIT_W-1:0] : w_cred_sel;
      // Dispenser is loaded on the cycle before CHANGE is entered.
      w_load     = (r_credit != '0) &&
                   ((w_ready_st && cancel) || (r_state == VEND));
   end

   vend_change_disp #(.CREDIT_W(CREDIT_W)) u_chg (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_amount  (r_credit),
      .chg_ready (chg_ready),
      .chg_valid (chg_valid),
      .chg_coin  (chg_coin),
      .o_accept  (w_accept),
      .o_acc_val (w_acc_val),
      .o_done    (w_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_credit      <= '0;
         r_coin_reject <= 1'b0;
         r_vend_valid  <= 1'b0;
         r_vend_item   <= '0;
         r_err_funds   <= 1'b0;
         r_err_soldout <= 1'b0;
         r_busy        <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         // Only an accepted coin in IDLE/CREDIT without cancel is kept.
         r_coin_reject <= coin_valid && !(w_ready_st && !cancel && w_coin_ok);
         r_vend_valid  <= w_vend;
         r_vend_item   <= w_vend ? sel_item : '0;
         r_err_soldout <= w_ready_st && !cancel && sel_valid && !w_in_stock;
         r_err_funds   <= w_ready_st && !cancel && sel_valid && w_in_stock && !w_afford;

         case (r_state)
            IDLE, CREDIT: begin
               if (cancel) begin
                  r_state <= (r_credit != '0) ? CHANGE : IDLE;
                  r_busy  <= (r_credit != '0);
               end else begin
                  r_credit <= w_cred_new;
                  r_busy   <= w_vend;
                  if (w_vend)                r_state <= VEND;
                  else if (w_cred_new != '0) r_state <= CREDIT;
                  else                       r_state <= IDLE;
               end
            end
            VEND: begin
               r_state <= (r_credit != '0) ? CHANGE : IDLE;
               r_busy  <= (r_credit != '0);
            end
            CHANGE: begin
               if (w_accept) r_credit <= r_credit - w_acc_val;
               if (w_done) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Restock loses to the decrement of the item sold this cycle.
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (w_vend && int'(sel_item) == i)
               r_stock[i] <= restock ? STOCK_W'(STOCK_INIT - 1) : r_stock[i] - STOCK_W'(1);
            else if (restock)
               r_stock[i] <= STOCK_W'(STOCK_INIT);
         end
      end
   end

   assign coin_reject = r_coin_reject;
   assign vend_valid  = r_vend_valid;
   assign vend_item   = r_vend_item;
   assign err_funds   = r_err_funds;
   assign err_soldout = r_err_soldout;
   assign credit      = r_credit;
   assign busy        = r_busy;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed scenarios then random traffic, every
// cycle compared against a credit/stock model of the vending rules.
module tb_vend_ctrl_multi;

   logic       clk, rst;
   logic       coin_valid, sel_valid, cancel, restock, chg_ready;
   logic [1:0] coin_type, sel_item;
   logic       coin_reject, vend_valid, err_funds, err_soldout, chg_valid, busy;
   logic [1:0] vend_item, chg_coin;
   logic [7:0] credit;

   vend_ctrl_multi dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
      .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .restock(restock),
      .coin_reject(coin_reject), .vend_valid(vend_valid), .vend_item(vend_item),
      .err_funds(err_funds), .err_soldout(err_soldout), .chg_valid(chg_valid),
      .chg_coin(chg_coin), .chg_ready(chg_ready), .credit(credit), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: phase 0 = taking coins, 1 = dispensing product, 2 = paying change.
   int price [4] = '{25, 20, 15, 10};
   int m_credit, m_phase;
   int m_stock [4];
   int e_rej, e_vv, e_vi, e_ef, e_es;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit cv, input bit [1:0] ct, input bit sv, input bit [1:0] si,
                        input bit can, input bit rsk, input bit rdy, input bit rr);
      int v, dec;
      e_rej = 0; e_vv = 0; e_vi = 0; e_ef = 0; e_es = 0; dec = -1;
      if (rr) begin
         m_credit = 0; m_phase = 0;
         foreach (m_stock[i]) m_stock[i] = 3;
         return;
      end
      case (m_phase)
         0: begin
            if (can) begin
               e_rej = cv;
               if (m_credit > 0) m_phase = 2;
            end else begin
               if (sv) begin
                  if (m_stock[si] == 0)              e_es = 1;
                  else if (m_credit < price[si])     e_ef = 1;
                  else begin
                     m_credit -= price[si]; dec = si; e_vv = 1; e_vi = si;
                  end
               end
               if (cv) begin
                  v = (ct == 1) ? 5 : (ct == 2) ? 10 : (ct == 3) ? 20 : 0;
                  if (v == 0 || m_credit + v > 100) e_rej = 1;
                  else m_credit += v;
               end
               if (e_vv) m_phase = 1;
            end
         end
         1: begin
            e_rej = cv;
            m_phase = (m_credit > 0) ? 2 : 0;
         end
         default: begin
            e_rej = cv;
            if (rdy) begin
               m_credit -= (m_credit >= 10) ? 10 : 5;
               if (m_credit == 0) m_phase = 0;
            end
         end
      endcase
      if (rsk) foreach (m_stock[i]) m_stock[i] = 3;
      if (dec >= 0) m_stock[dec] = rsk ? 2 : m_stock[dec] - 1;
   endtask

   task automatic step(input bit cv, input bit [1:0] ct, input bit sv, input bit [1:0] si,
                       input bit can, input bit rsk, input bit rdy, input bit rr);
      @(negedge clk);
      coin_valid = cv; coin_type = ct; sel_valid = sv; sel_item = si;
      cancel = can; restock = rsk; chg_ready = rdy; rst = rr;
      @(posedge clk);
      model(cv, ct, sv, si, can, rsk, rdy, rr);
      #1;
      chk("coin_reject", 32'(coin_reject), 32'(e_rej));
      chk("vend_valid",  32'(vend_valid),  32'(e_vv));
      chk("vend_item",   32'(vend_item),   32'(e_vi));
      chk("err_funds",   32'(err_funds),   32'(e_ef));
      chk("err_soldout", 32'(err_soldout), 32'(e_es));
      chk("chg_valid",   32'(chg_valid),   32'(m_phase == 2));
      chk("chg_coin",    32'(chg_coin),
          (m_phase == 2) ? ((m_credit >= 10) ? 32'd2 : 32'd1) : 32'd0);
      chk("credit",      32'(credit),      32'(m_credit));
      chk("busy",        32'(busy),        32'(m_phase != 0));
   endtask

   task automatic coin(input bit [1:0] ct);  step(1, ct, 0, 0, 0, 0, 0, 0); endtask
   task automatic sel(input bit [1:0] si);   step(0, 0, 1, si, 0, 0, 0, 0); endtask
   task automatic nop(input bit rdy);        step(0, 0, 0, 0, 0, 0, rdy, 0); endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; coin_valid = 0; coin_type = 0; sel_valid = 0; sel_item = 0;
      cancel = 0; restock = 0; chg_ready = 0;
      m_credit = 0; m_phase = 0;
      foreach (m_stock[i]) m_stock[i] = 3;

      // reset state
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 2'b11, 1, 0, 1, 1, 1, 1);

      // exact payment, no change
      coin(2'b10); coin(2'b10); coin(2'b01); sel(0); nop(0);

      // overpay then greedy change 10,10,5
      coin(2'b11); coin(2'b11); sel(2);
      for (int k = 0; k < 8 && m_phase != 0; k++) nop(1);
      chk("idle_after_change", 32'(busy), 32'd0);

      // insufficient funds, then top up and buy
      coin(2'b01); sel(3); coin(2'b01); sel(3); nop(0);

      // sell out item1, soldout keeps credit, restock, buy again
      for (int k = 0; k < 3; k++) begin coin(2'b11); sel(1); nop(0); end
      coin(2'b11); sel(1);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      sel(1); nop(0);

      // fill to 95, overflow coin rejected, invalid coin rejected
      for (int k = 0; k < 4; k++) coin(2'b11);
      coin(2'b10); coin(2'b01); coin(2'b10); coin(2'b00);
      // refund with a stalling hopper
      step(0, 0, 1, 0, 1, 0, 0, 0);
      for (int k = 0; k < 60 && m_phase != 0; k++) nop(1'(k % 2 == 0));
      chk("idle_after_refund", 32'(busy), 32'd0);

      // reset in the middle of a refund
      coin(2'b11); coin(2'b11);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      nop(1);
      step(1, 2'b01, 0, 0, 0, 0, 1, 1);
      nop(1);

      // random traffic
      for (int k = 0; k < 600; k++)
         step(1'($urandom_range(0, 2) == 0), 2'($urandom),
              1'($urandom_range(0, 3) == 0), 2'($urandom),
              1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 31) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
